monitor_output_collector: RTL and testbench
===========================================

// Module: monitor_output_collector
// PURPOSE
//   Downstream sink for the compiled monitor (topEntity). Samples output_N/output_N_aktv
//   each cycle; whenever any aktv bit is set, stores one record (all output values, aktv
//   mask, cycle timestamp) in a FIFO and streams records out over a valid/ready port.
//   Decouples the monitor's bursty verdicts from a slower consumer (UART/host bridge).
// PARAMETERS
//   NUM_OUT  4   number of monitor output streams
//   DATA_W   64  width of each output value (signed, passed through unmodified)
//   DEPTH    8   FIFO entries; power of two, >= 2
//   TS_W     32  timestamp counter width
// PORTS
//   clk        in   1              rising-edge clock, same clock as monitor
//   rst        in   1              asynchronous, active-high reset
//   en         in   1              global enable, same signal as monitor en
//   mon_data   in   NUM_OUT*DATA_W output_0 at [DATA_W-1:0], output_k at slice k
//   mon_aktv   in   NUM_OUT        output_k_aktv at bit k
//   rec_valid  out  1              head record available
//   rec_ready  in   1              consumer accepts head record
//   rec_data   out  NUM_OUT*DATA_W head record values
//   rec_aktv   out  NUM_OUT        head record aktv mask (never zero when rec_valid)
//   rec_ts     out  TS_W           head record capture timestamp
//   level      out  $clog2(DEPTH)+1 number of stored records
//   overflow   out  1              sticky: a record was dropped
//   drop_cnt   out  16             dropped-record count, saturates at 16'hFFFF
//   clr_ovf    in   1              synchronous pulse: clears overflow and drop_cnt
// BEHAVIOUR
//   - Reset (async assert): FIFO empty, rec_valid=0, rec_data/aktv/ts=0, level=0,
//     overflow=0, drop_cnt=0, ts counter=0. Reset mid-stream flushes all records.
//   - ts counter: +1 every cycle with en=1, wraps 2^TS_W-1 -> 0; holds when en=0.
//   - Capture: at posedge with en=1 and |mon_aktv: push {mon_data, mon_aktv, ts}; ts is
//     counter value before that edge's increment. en=0 -> no capture.
//   - Latency: record captured at edge N drives rec_valid=1 after edge N (visible in
//     cycle N+1) when FIFO was empty. Outputs come from registers/RAM read regs, no
//     combinational path from mon_* to rec_*.
//   - Handshake: pop at posedge when rec_valid & rec_ready. rec_* stable while
//     rec_valid=1 and rec_ready=0. rec_valid never drops without a pop.
//   - Full (level==DEPTH) and capture without pop: record dropped, overflow<=1,
//     drop_cnt<=drop_cnt+1 (saturating); stored contents unchanged.
//   - Full with simultaneous pop and capture: both occur, level stays DEPTH, no drop.
//   - Empty with capture and rec_ready=1: no bypass; record appears next cycle.
//   - clr_ovf with a drop in same cycle: drop wins -> overflow=1, drop_cnt=1.
//   - Pointers: log2(DEPTH)-bit, wrap naturally; level = wr-rd with extra MSB.
//   - Order: strict FIFO; records leave in capture order.
// CONFIGURATION
//   OUTCOL_TS_EN defined: ts counter built, rec_ts carries capture timestamp.
//   OUTCOL_TS_EN undefined: counter and ts storage removed, rec_ts tied to 0;
//   all other behaviour identical.
// TESTING
//   1. rst held 2 cycles, then idle 10 cycles, mon_aktv=0 -> rec_valid=0, level=0,
//      all outputs 0 throughout.
//   2. one-cycle pulse mon_aktv=4'b0101, output_0=1, output_2=-3, rec_ready=1 ->
//      exactly one record, rec_aktv=0101, values 1/-3 (sign preserved), rec_ts equals
//      cycles since rst release, level returns to 0.
//   3. rec_ready=0, 10 consecutive captures values 1..10 -> level=8, records 1..8 kept,
//      overflow=1, drop_cnt=2; then rec_ready=1 drains 1..8 in order.
//   4. full FIFO, rec_ready=1 plus capture every cycle for 20 cycles -> level stays 8,
//      drop_cnt unchanged, output sequence gapless and ordered.
//   5. rst asserted mid-drain with level=5 -> rec_valid=0, level=0 immediately
//      (asynchronous), no stale record after release; clr_ovf pulse zeroes
//      drop_cnt=2 -> 0.
//   6. en=0 for 5 cycles with mon_aktv=1111 -> no capture, ts frozen; build without
//      OUTCOL_TS_EN -> scenario 2 gives rec_ts=0, values identical.

Source files
------------

// File: rtl/monitor_output_collector.sv
// Record FIFO behind the monitor: captures {values, aktv mask, timestamp} whenever any aktv
// bit is set and streams records out over valid/ready. OUTCOL_TS_EN builds the timestamp path.
module monitor_output_collector #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] mon_data,
  input  logic [NUM_OUT-1:0]        mon_aktv,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [NUM_OUT*DATA_W-1:0] rec_data,
  output logic [NUM_OUT-1:0]        rec_aktv,
  output logic [TS_W-1:0]           rec_ts,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  input  logic                      clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [NUM_OUT*DATA_W-1:0] mem_data [DEPTH];
  logic [NUM_OUT-1:0]        mem_aktv [DEPTH];
  logic capture, pop, push, drop, full;

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == FULL_LVL);
  assign rec_valid = (level != '0);
  assign pop       = rec_valid & rec_ready;
  assign capture   = en & (|mon_aktv);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  assign rec_data = mem_data[rd_ptr[AW-1:0]];
  assign rec_aktv = mem_aktv[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_aktv[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr[AW-1:0]] <= mon_data;
        mem_aktv[wr_ptr[AW-1:0]] <= mon_aktv;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A drop in the same cycle as clr_ovf restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                 drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

`ifdef OUTCOL_TS_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] mem_ts [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem_ts[i] <= '0;
    end else begin
      if (en)   ts_cnt <= ts_cnt + TS_W'(1);
      if (push) mem_ts[wr_ptr[AW-1:0]] <= ts_cnt;
    end
  end

  assign rec_ts = mem_ts[rd_ptr[AW-1:0]];
`else
  assign rec_ts = '0;
`endif

endmodule

// File: tb/tb_monitor_output_collector.sv
// Scoreboard bench for monitor_output_collector: a model process queues expected records at
// each capture edge, a negedge monitor pops and compares on every handshake.
module tb_monitor_output_collector;
  localparam int N = 4, W = 64, D = 8, T = 32;

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, rec_ready = 1'b0, clr_ovf = 1'b0;
  logic [N*W-1:0] mon_data = '0;
  logic [N-1:0]   mon_aktv = '0;
  logic           rec_valid, overflow;
  logic [N*W-1:0] rec_data;
  logic [N-1:0]   rec_aktv;
  logic [T-1:0]   rec_ts;
  logic [3:0]     level;
  logic [15:0]    drop_cnt;

  monitor_output_collector #(.NUM_OUT(N), .DATA_W(W), .DEPTH(D), .TS_W(T)) dut (
    .clk(clk), .rst(rst), .en(en), .mon_data(mon_data), .mon_aktv(mon_aktv),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data), .rec_aktv(rec_aktv),
    .rec_ts(rec_ts), .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] d;
    logic [N-1:0]   a;
    logic [T-1:0]   ts;
  } rec_t;

  rec_t q[$];
  int mlevel = 0;
  logic [T-1:0] mts = '0;
  int total = 0, bad = 0, npop = 0;
  logic [N*W-1:0] last_d = '0;
  logic [T-1:0]   last_ts = '0;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, timestamp counter and expected-record queue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mlevel = 0;
      mts = '0;
      q.delete();
    end else begin
      automatic bit popm = (mlevel > 0) && rec_ready;
      automatic rec_t r;
      if (en && (|mon_aktv) && (mlevel < D || popm)) begin
        r.d = mon_data;
        r.a = mon_aktv;
`ifdef OUTCOL_TS_EN
        r.ts = mts;
`else
        r.ts = '0;
`endif
        q.push_back(r);
        mlevel++;
      end
      if (popm) mlevel--;
      if (en) mts++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("level", N*W'(level), N*W'(mlevel));
      chk("valid", N*W'(rec_valid), N*W'(mlevel != 0));
      if (rec_valid && rec_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rec", N*W'(1), N*W'(0));
        end else begin
          automatic rec_t e = q.pop_front();
          chk("rec_data", rec_data, e.d);
          chk("rec_aktv", N*W'(rec_aktv), N*W'(e.a));
          chk("rec_ts", N*W'(rec_ts), N*W'(e.ts));
          npop++;
          last_d = rec_data;
          last_ts = rec_ts;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [N-1:0] a, input logic [N*W-1:0] d);
    mon_aktv = a;
    mon_data = d;
    step();
    mon_aktv = '0;
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    mon_aktv = '0;
    for (int i = 0; i < 40 && mlevel != 0; i++) step();
    step();
    chk("drain_level", N*W'(level), '0);
    chk("drain_queue", N*W'(q.size()), '0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, N*W'(rec_valid), '0);
    chk({tag, "_level"}, N*W'(level), '0);
    chk({tag, "_data"}, rec_data, '0);
    chk({tag, "_aktv"}, N*W'(rec_aktv), '0);
    chk({tag, "_ts"}, N*W'(rec_ts), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int p0;
    logic [T-1:0] a_ts;
    // 1: reset, then idle
    step(); step();
    chk_idle("rst");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle");
      chk("idle_ovf", N*W'(overflow), '0);
      chk("idle_drop", N*W'(drop_cnt), '0);
    end

    // 2: one pulse; 10 counted edges since release, so ts=10
    rec_ready = 1'b1;
    p0 = npop;
    cap(4'b0101, {64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd1});
    step(); step();
    chk("s2_count", N*W'(npop - p0), N*W'(1));
    chk("s2_data", last_d, {64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'd1});
`ifdef OUTCOL_TS_EN
    chk("s2_ts", N*W'(last_ts), N*W'(10));
`else
    chk("s2_ts", N*W'(last_ts), '0);
`endif
    chk("s2_level", N*W'(level), '0);

    // 3: overfill with consumer stalled
    rec_ready = 1'b0;
    for (int k = 1; k <= 10; k++) cap(4'b0001, N*W'(k));
    chk("s3_level", N*W'(level), N*W'(8));
    chk("s3_ovf", N*W'(overflow), N*W'(1));
    chk("s3_drop", N*W'(drop_cnt), N*W'(2));

    // 4: full FIFO, pop and capture every cycle
    rec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cap(4'b0001, N*W'(100 + i));
      chk("s4_level", N*W'(level), N*W'(8));
    end
    chk("s4_drop", N*W'(drop_cnt), N*W'(2));
    drain();

    // 5: clr_ovf, drop-vs-clear priority, async reset mid-drain
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("s5_clr_drop", N*W'(drop_cnt), '0);
    chk("s5_clr_ovf", N*W'(overflow), '0);
    rec_ready = 1'b0;
    for (int k = 1; k <= 8; k++) cap(4'b0010, N*W'(k << 64));
    clr_ovf = 1'b1;
    cap(4'b0010, N*W'(99));
    clr_ovf = 1'b0;
    chk("s5_prio_ovf", N*W'(overflow), N*W'(1));
    chk("s5_prio_drop", N*W'(drop_cnt), N*W'(1));
    rec_ready = 1'b1;
    step(); step(); step();
    chk("s5_mid_level", N*W'(level), N*W'(5));
    rec_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_idle("s5_async");
    step();
    rst = 1'b0;
    rec_ready = 1'b1;
    p0 = npop;
    repeat (3) step();
    chk("s5_no_stale", N*W'(npop - p0), '0);

    // 6: en=0 freezes capture and ts
    cap(4'b1000, {64'd7, 192'd0});
    step();
    a_ts = last_ts;
    en = 1'b0;
    mon_aktv = 4'b1111;
    mon_data = {4{64'hDEAD}};
    repeat (5) step();
    chk("s6_level", N*W'(level), '0);
    en = 1'b1;
    p0 = npop;
    cap(4'b1111, {64'd4, 64'd3, 64'd2, 64'd1});
    step(); step();
    chk("s6_count", N*W'(npop - p0), N*W'(1));
`ifdef OUTCOL_TS_EN
    chk("s6_ts_frozen", N*W'(last_ts - a_ts), N*W'(2));
`else
    chk("s6_ts_frozen", N*W'(last_ts - a_ts), '0);
`endif
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
